// File: rtl/alu_pkg.sv
// Shared definitions for the decode/issue stage and the EX-stage ALU.
// Holds the ALU opcode encoding, the bit positions of every field in the
// 16-bit instruction word, the register index width and a small helper
// that slices an instruction word into its fields.
package alu_pkg;

  localparam int REG_IDX_W = 2;
  localparam int NREG      = 4;

  // Instruction layout: op[15:12] rd[11:10] rs1[9:8] rs2[7:6], imm8 overlays [7:0]
  localparam int OP_LSB   = 12;
  localparam int OP_W     = 4;
  localparam int RD_LSB   = 10;
  localparam int RS1_LSB  = 8;
  localparam int RS2_LSB  = 6;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 8;
  localparam int IMM_FLAG = 15;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7
  } alu_op_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    reg_idx_t         rd;
    reg_idx_t         rs1;
    reg_idx_t         rs2;
    logic [IMM_W-1:0] imm8;
  } instr_fields_t;

  function automatic instr_fields_t decodeFields(input logic [15:0] instr);
    instr_fields_t f;
    f.op   = instr[OP_LSB  +: OP_W];
    f.rd   = instr[RD_LSB  +: REG_IDX_W];
    f.rs1  = instr[RS1_LSB +: REG_IDX_W];
    f.rs2  = instr[RS2_LSB +: REG_IDX_W];
    f.imm8 = instr[IMM_LSB +: IMM_W];
    return f;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Four-entry register file for the issue stage.
// Ports:
//   clk, rst_n        clock and synchronous active-low clear of all entries
//   we, waddr, wdata  single write port (driven by EX write-back)
//   raddr1/rdata1     asynchronous read port for rs1
//   raddr2/rdata2     asynchronous read port for rs2
// A write in the same cycle as a read of the same index is bypassed onto
// the read data, which is how the stage forwards write-back results.
module id_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  reg_idx_t         waddr,
  input  logic [WIDTH-1:0] wdata,
  input  reg_idx_t         raddr1,
  input  reg_idx_t         raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
  assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage feeding the EX-stage ALU.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_ready/in_instr   instruction handshake from IF
//   out_valid/out_ready          registered issue packet handshake to EX
//   out_a/out_b/out_opcode/out_rd  ALU operands, opcode (4'b0xxx), destination
//   wb_valid/wb_rd/wb_data       EX write-back port
//   stall                        combinational hazard indicator
// A per-register pending bit (scoreboard) blocks RAW and WAW hazards; a
// write-back in the same cycle releases the hazard and is forwarded.
module id_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_opcode,
  output logic [1:0]       out_rd,
  input  logic             wb_valid,
  input  logic [1:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall
);

  instr_fields_t    fields;
  logic             immForm;
  logic [WIDTH-1:0] rdata1, rdata2, immExt;
  logic             rs1Ready, rs2Ready, rdFree, accept;

  logic [NREG-1:0]  pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [3:0]       out_opcode_q, out_opcode_d;
  reg_idx_t         out_rd_q, out_rd_d;

  assign fields  = decodeFields(in_instr);
  assign immForm = in_instr[IMM_FLAG];

  // Same-index write-back bypass in the register file doubles as operand forwarding
  id_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_valid),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (fields.rs1),
    .raddr2 (fields.rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_comb begin
    immExt = {WIDTH{fields.imm8[IMM_W-1]}};
    immExt[IMM_W-1:0] = fields.imm8;
  end

  // A pending register is usable when its result arrives this very cycle
  assign rs1Ready = !pending_q[fields.rs1] || (wb_valid && (wb_rd == fields.rs1));
  assign rs2Ready = !pending_q[fields.rs2] || (wb_valid && (wb_rd == fields.rs2));
  assign rdFree   = !pending_q[fields.rd]  || (wb_valid && (wb_rd == fields.rd));

  assign stall    = in_valid && (!rs1Ready || (!immForm && !rs2Ready) || !rdFree);
  assign in_ready = (!out_valid_q || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    pending_d    = pending_q;
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_opcode_d = out_opcode_q;
    out_rd_d     = out_rd_q;

    // Clear before set so an accept targeting the written-back register keeps it pending
    if (wb_valid) pending_d[wb_rd] = 1'b0;

    if (accept) begin
      pending_d[fields.rd] = 1'b1;
      out_valid_d  = 1'b1;
      out_a_d      = rdata1;
      out_b_d      = immForm ? immExt : rdata2;
      out_opcode_d = {1'b0, fields.op[2:0]};
      out_rd_d     = fields.rd;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_opcode_q <= '0;
      out_rd_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_opcode_q <= out_opcode_d;
      out_rd_q     <= out_rd_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_opcode = out_opcode_q;
  assign out_rd     = out_rd_q;

endmodule
